// File: rtl/nios2_debug_host_jtag_seq_pkg.sv
// Shared types and constants for the Nios II debug host JTAG sequencer.
// Holds the sequencer state enum, default scan width and slave IR codes.
package nios2_debug_host_jtag_seq_pkg;

    localparam int DR_WIDTH_DEF = 38;

    // Instruction codes decoded by the debug slave's ir_in.
    localparam logic [1:0] IR_MONITOR = 2'b00;
    localparam logic [1:0] IR_OCIMEM  = 2'b01;
    localparam logic [1:0] IR_BREAK   = 2'b10;
    localparam logic [1:0] IR_TRACE   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_RSP
    } state_t;

endpackage

// File: rtl/nios2_debug_host_jtag_seq_if.sv
// Command/response handshake bundle between a host and the sequencer.
// master: drives cmd_valid/cmd_ir/cmd_data/rsp_ready; slave: the rest.
interface nios2_debug_host_jtag_seq_if
    import nios2_debug_host_jtag_seq_pkg::*;
#(
    parameter int DR_WIDTH = DR_WIDTH_DEF
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_ir;
    logic [DR_WIDTH-1:0] cmd_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DR_WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_ir, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/nios2_debug_host_tck_gen.sv
// TCK generator: one TCK period is 2*TCK_DIV clk cycles, low half first.
// Ports: clk, reset_n, en in; tck, phase_start, tck_rise, phase_end out.
module nios2_debug_host_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic tck,
    output logic phase_start,
    output logic tck_rise,
    output logic phase_end
);
    localparam int PW = $clog2(2 * TCK_DIV);
    localparam logic [PW-1:0] HALF = PW'(TCK_DIV);
    localparam logic [PW-1:0] LAST = PW'(2 * TCK_DIV - 1);

    logic [PW-1:0] cnt;

    // Held at zero while disabled so every phase starts on a clean period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tck         = en && (cnt >= HALF);
    assign phase_start = en && (cnt == '0);
    assign tck_rise    = en && (cnt == HALF);
    assign phase_end   = en && (cnt == LAST);

endmodule

// File: rtl/nios2_debug_host_jtag_seq.sv
// Host-side virtual-JTAG sequencer for the Nios II debug slave.
// Ports: clk, reset_n, host (cmd/rsp handshake, slave modport), vji_* strobes.
// Option NIOS2_DBG_HOST_IR_CACHE_EN: skip UIR when the IR is unchanged.
module nios2_debug_host_jtag_seq
    import nios2_debug_host_jtag_seq_pkg::*;
#(
    parameter int TCK_DIV  = 2,
    parameter int DR_WIDTH = DR_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset_n,
    nios2_debug_host_jtag_seq_if.slave   host,
    output logic                         vji_tck,
    output logic                         vji_tdi,
    input  logic                         vji_tdo,
    output logic [1:0]                   vji_ir_in,
    output logic                         vji_rti,
    output logic                         vji_uir,
    output logic                         vji_cdr,
    output logic                         vji_sdr,
    output logic                         vji_udr
);
    localparam int BW = $clog2(DR_WIDTH + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);

    state_t              state;
    state_t              state_nx;
    logic [DR_WIDTH-1:0] data_q;
    logic [DR_WIDTH-1:0] cap_q;
    logic [BW-1:0]       bit_cnt;
    logic [1:0]          ir_q;
    logic                en;
    logic                accept;
    logic                ir_hit;
    logic                phase_start;
    logic                tck_rise;
    logic                phase_end;

    nios2_debug_host_tck_gen #(
        .TCK_DIV(TCK_DIV)
    ) u_tck_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .tck        (vji_tck),
        .phase_start(phase_start),
        .tck_rise   (tck_rise),
        .phase_end  (phase_end)
    );

    assign en     = state inside {ST_UIR, ST_CDR, ST_SDR, ST_UDR};
    assign accept = (state == ST_IDLE) && host.cmd_valid;

`ifdef NIOS2_DBG_HOST_IR_CACHE_EN
    logic ir_loaded;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_loaded <= 1'b0;
        end else if (accept) begin
            ir_loaded <= 1'b1;
        end
    end

    assign ir_hit = ir_loaded && (host.cmd_ir == ir_q);
`else
    assign ir_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (accept)    state_nx = ir_hit ? ST_CDR : ST_UIR;
            ST_UIR:  if (phase_end) state_nx = ST_CDR;
            ST_CDR:  if (phase_end) state_nx = ST_SDR;
            ST_SDR:  if (phase_end && bit_cnt == BIT_LAST) state_nx = ST_UDR;
            ST_UDR:  if (phase_end) state_nx = ST_RSP;
            ST_RSP:  if (host.rsp_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // ir_q doubles as vji_ir_in: it changes only when a UIR phase follows.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            cap_q   <= '0;
            ir_q    <= '0;
            bit_cnt <= '0;
        end else begin
            if (accept) begin
                data_q <= host.cmd_data;
                if (!ir_hit) begin
                    ir_q <= host.cmd_ir;
                end
            end
            if (state == ST_SDR) begin
                if (phase_end && bit_cnt != BIT_LAST) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else begin
                bit_cnt <= '0;
            end
            if (state == ST_CDR && phase_start) begin
                cap_q <= '0;
            end
            if (state == ST_SDR && tck_rise) begin
                cap_q[bit_cnt] <= vji_tdo;
            end
        end
    end

    assign host.cmd_ready = (state == ST_IDLE);
    assign host.rsp_valid = (state == ST_RSP);
    assign host.rsp_data  = cap_q;

    assign vji_ir_in = ir_q;
    assign vji_rti   = (state == ST_IDLE);
    assign vji_uir   = (state == ST_UIR);
    assign vji_cdr   = (state == ST_CDR);
    assign vji_sdr   = (state == ST_SDR);
    assign vji_udr   = (state == ST_UDR);
    assign vji_tdi   = (state == ST_SDR) ? data_q[bit_cnt] : 1'b0;

endmodule

// File: tb/tb_nios2_debug_host_jtag_seq.sv
// Self-checking bench for nios2_debug_host_jtag_seq.
// Cycle-level reference model plus directed commands with literal results.
module tb_nios2_debug_host_jtag_seq;
    import nios2_debug_host_jtag_seq_pkg::*;

    localparam int TCK_DIV = 2;
    localparam int DR      = 38;
    localparam int P       = 2 * TCK_DIV;
`ifdef NIOS2_DBG_HOST_IR_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       lb = 1'b1;
    logic       vji_tck, vji_tdi, vji_tdo;
    logic [1:0] vji_ir_in;
    logic       vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr;
    int         errs = 0;
    int         checks = 0;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nios2_debug_host_jtag_seq_if #(.DR_WIDTH(DR)) hif ();

    assign vji_tdo = lb ? vji_tdi : 1'b1;

    nios2_debug_host_jtag_seq #(
        .TCK_DIV (TCK_DIV),
        .DR_WIDTH(DR)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .host     (hif),
        .vji_tck  (vji_tck),
        .vji_tdi  (vji_tdi),
        .vji_tdo  (vji_tdo),
        .vji_ir_in(vji_ir_in),
        .vji_rti  (vji_rti),
        .vji_uir  (vji_uir),
        .vji_cdr  (vji_cdr),
        .vji_sdr  (vji_sdr),
        .vji_udr  (vji_udr)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errs++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // Reference model: position within a command is derived from the
    // cycle offset since acceptance, not from any sequencer state.
    initial begin
        int         m_mode = 0;
        int         m_t = 0;
        int         p, w, len;
        bit         m_skip = 0;
        bit         m_seen = 0;
        bit         m_lb = 1;
        logic [1:0] m_ir = '0;
        logic [DR-1:0] m_data = '0;
        logic [DR-1:0] m_rsp = '0;
        logic [6:0] e_str;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk("rst_ready", hif.cmd_ready, 1);
                chk("rst_rsp_valid", hif.rsp_valid, 0);
                chk("rst_rsp_data", hif.rsp_data, 0);
                chk("rst_ir_in", vji_ir_in, 0);
                chk("rst_strobes",
                    {vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr,
                     vji_tck, vji_tdi}, 7'b1000000);
                m_mode = 0;
                m_seen = 0;
                m_ir   = '0;
                m_rsp  = '0;
            end else begin
                e_str = 7'b0;
                if (m_mode == 0) begin
                    e_str = 7'b1000000;
                end else if (m_mode == 1) begin
                    p = (m_t - 1) / P + (m_skip ? 1 : 0);
                    w = (m_t - 1) % P;
                    e_str[1] = (w >= TCK_DIV);
                    if (p == 0) e_str[5] = 1'b1;
                    if (p == 1) e_str[4] = 1'b1;
                    if (p >= 2 && p <= DR + 1) begin
                        e_str[3] = 1'b1;
                        e_str[0] = m_data[p-2];
                    end
                    if (p == DR + 2) e_str[2] = 1'b1;
                end
                chk("strobes",
                    {vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr,
                     vji_tck, vji_tdi}, e_str);
                chk("cmd_ready", hif.cmd_ready, m_mode == 0);
                chk("rsp_valid", hif.rsp_valid, m_mode == 2);
                chk("ir_in", vji_ir_in, m_ir);
                if (m_mode == 2) chk("rsp_data", hif.rsp_data, m_rsp);

                if (m_mode == 0) begin
                    if (hif.cmd_valid) begin
                        m_skip = CACHE && m_seen && (hif.cmd_ir == m_ir);
                        m_data = hif.cmd_data;
                        m_lb   = lb;
                        if (!m_skip) begin
                            m_ir   = hif.cmd_ir;
                            m_seen = 1;
                        end
                        m_mode = 1;
                        m_t    = 1;
                    end
                end else if (m_mode == 1) begin
                    len = m_skip ? P * (DR + 2) : P * (DR + 3);
                    if (m_t == len) begin
                        m_mode = 2;
                        m_rsp  = m_lb ? m_data : '1;
                    end else begin
                        m_t++;
                    end
                end else if (hif.rsp_ready) begin
                    m_mode = 0;
                end
            end
        end
    end

    task automatic send(input logic [1:0] ir, input logic [DR-1:0] d,
                        output int hs);
        @(posedge clk);
        #1;
        hif.cmd_valid = 1'b1;
        hif.cmd_ir    = ir;
        hif.cmd_data  = d;
        hs = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (hif.cmd_ready) begin
                hs = cyc;
                break;
            end
        end
        if (hs < 0) fail("accept");
        @(posedge clk);
        #1;
        hif.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int hs, output int lat, output int n_sdr,
                            output int n_uir, output int n_tdi);
        lat = -1;
        n_sdr = 0;
        n_uir = 0;
        n_tdi = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n_sdr += int'(vji_sdr);
            n_uir += int'(vji_uir);
            n_tdi += int'(vji_tdi);
            if (hif.rsp_valid) begin
                lat = cyc - hs;
                break;
            end
        end
        if (lat < 0) fail("rsp_valid");
    endtask

    task automatic release_rsp(input int hold, input logic [DR-1:0] exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (i == 5) begin
                hif.cmd_valid = 1'b1;
                hif.cmd_ir    = IR_MONITOR;
                hif.cmd_data  = 38'h1;
            end
            if (i == 6) hif.cmd_valid = 1'b0;
        end
        @(negedge clk);
        chk("held_rsp_data", hif.rsp_data, exp);
        chk("held_cmd_ready", hif.cmd_ready, 0);
        @(posedge clk);
        #1;
        hif.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        hif.rsp_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_rsp", hif.cmd_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hs, lat, n_sdr, n_uir, n_tdi, n_rv;
        hif.cmd_valid = 1'b0;
        hif.cmd_ir    = '0;
        hif.cmd_data  = '0;
        hif.rsp_ready = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd_ready", hif.cmd_ready, 1);
        chk("reset_rti", vji_rti, 1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Loopback: capture equals data shifted out.
        lb = 1'b1;
        send(IR_OCIMEM, 38'h2A_5555_5555, hs);
        wait_rsp(hs, lat, n_sdr, n_uir, n_tdi);
        chk("lat_loopback", lat, 165);
        chk("data_loopback", hif.rsp_data, 38'h2A_5555_5555);
        chk("ir_loopback", vji_ir_in, 2'b01);
        chk("uir_cycles", n_uir, 4);
        release_rsp(0, 38'h2A_5555_5555);

        // TDO tied high, zero data, response held off for 20 cycles.
        lb = 1'b0;
        send(IR_TRACE, 38'h0, hs);
        wait_rsp(hs, lat, n_sdr, n_uir, n_tdi);
        chk("lat_tie1", lat, 165);
        chk("data_tie1", hif.rsp_data, 38'h3F_FFFF_FFFF);
        chk("sdr_cycles", n_sdr, 152);
        chk("tdi_high_cycles", n_tdi, 0);
        release_rsp(20, 38'h3F_FFFF_FFFF);
        lb = 1'b1;

        // rsp_ready already high when rsp_valid rises.
        send(IR_BREAK, 38'h15_0F0F_3C3C, hs);
        hif.rsp_ready = 1'b1;
        wait_rsp(hs, lat, n_sdr, n_uir, n_tdi);
        chk("lat_break1", lat, 165);
        chk("data_break1", hif.rsp_data, 38'h15_0F0F_3C3C);
        @(posedge clk);
        #1;
        hif.rsp_ready = 1'b0;
        @(negedge clk);
        chk("early_ready_idle", hif.cmd_ready, 1);

        // Same IR again: UIR skipped only with the IR cache.
        send(IR_BREAK, 38'h3F_0000_0001, hs);
        wait_rsp(hs, lat, n_sdr, n_uir, n_tdi);
        chk("lat_break2", lat, CACHE ? 161 : 165);
        chk("uir_break2", n_uir, CACHE ? 0 : 4);
        chk("data_break2", hif.rsp_data, 38'h3F_0000_0001);
        release_rsp(0, 38'h3F_0000_0001);

        // Reset while shifting bit 10.
        send(IR_OCIMEM, 38'h00_DEAD_BEEF, hs);
        repeat (48) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_ready", hif.cmd_ready, 1);
        chk("midrst_sdr", vji_sdr, 0);
        chk("midrst_ir_in", vji_ir_in, 0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        n_rv = 0;
        repeat (200) begin
            @(negedge clk);
            n_rv += int'(hif.rsp_valid);
        end
        chk("no_rsp_after_reset", n_rv, 0);

        send(IR_OCIMEM, 38'h12_3456_789A, hs);
        wait_rsp(hs, lat, n_sdr, n_uir, n_tdi);
        chk("lat_after_reset", lat, 165);
        chk("uir_after_reset", n_uir, 4);
        chk("data_after_reset", hif.rsp_data, 38'h12_3456_789A);
        release_rsp(0, 38'h12_3456_789A);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
